// File: rtl/ctrl_pkg.sv
// Control encodings shared between the fetch stage and the control unit.
// Also holds the branch/jump resolution rule so both sides agree on it.
package ctrl_pkg;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_BNE   = 2'b10;
    localparam logic [1:0] BR_BEQ   = 2'b11;
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JALR = 2'b11;

    // Jumps always redirect; a branch redirects when the zero flag matches BEQ/BNE sense.
    function automatic logic resolve_taken(input logic [1:0] br,
                                           input logic [1:0] jmp,
                                           input logic       zero);
        return jmp[1] | (br[1] & (zero == br[0]));
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// Two-entry FIFO of {instr, pc} pairs between imem return and decode.
// Head is presented straight from the storage registers.
module instr_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_instr,
    input  logic [W-1:0] push_pc,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_instr,
    output logic [W-1:0] head_pc
);

    logic [W-1:0] instr_mem [2];
    logic [W-1:0] pc_mem    [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         pop_eff;

    assign pop_eff = pop & (count_reg != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    instr_mem[gi] <= push_instr;
                    pc_mem[gi]    <= push_pc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_eff)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop_eff})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The fetch issue rule reserves a slot for every outstanding request.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && (count_reg == 2'd2)));

    assign count      = count_reg;
    assign head_valid = (count_reg != 2'd0);
    assign head_instr = instr_mem[rd_ptr_reg];
    assign head_pc    = pc_mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers returned
// words for decode and redirects on resolved branches/jumps from execute.
module fetch_unit
    import ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic [1:0]            ex_branch,
    input  logic [1:0]            ex_jump,
    input  logic                  ex_zero,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic                  inflight_reg;
    logic [DATA_WIDTH-1:0] inflight_pc_reg;

    logic                  run;
    logic                  pop;
    logic                  push;
    logic [1:0]            count;
    logic [2:0]            occupancy;

    assign run = (state_reg == ST_RUN);
    assign redirect = run & resolve_taken(ex_branch, ex_jump, ex_zero);
    assign redirect_pc = (ex_jump == JMP_JALR) ? (ex_alu_result & ~DATA_WIDTH'(1))
                                               : (ex_pc + ex_imm);

    // Slots already spoken for: buffered words plus the word still in flight.
    assign pop       = instr_valid & instr_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign imem_req  = run & ~redirect & (occupancy < 3'd2);
    assign imem_addr = pc_reg;
    assign push      = inflight_reg & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg    <= ST_RUN;
            inflight_reg <= imem_req;
            if (imem_req)
                inflight_pc_reg <= pc_reg;
            if (redirect)
                pc_reg <= redirect_pc;
            else if (imem_req)
                pc_reg <= pc_reg + DATA_WIDTH'(4);
        end
    end

    instr_buffer #(
        .W (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (inflight_pc_reg),
        .pop        (pop & ~redirect),
        .flush      (redirect),
        .count      (count),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based model of the fetch stage is checked
// against the DUT every cycle, plus directed literal expectations.
module tb_fetch_unit;
    import ctrl_pkg::*;

    localparam logic [31:0] K = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  ex_branch;
    logic [1:0]  ex_jump;
    logic        ex_zero;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_alu_result;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_zero       (ex_zero),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_alu_result (ex_alu_result),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    // Model state: program counter, outstanding read, decode-side queue.
    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_inflight;
    logic [31:0] m_inflight_pc;
    logic        m_run;
    logic        e_req, e_redirect, e_pop;
    logic [31:0] e_rpc;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc          = 32'h0;
        m_inflight    = 1'b0;
        m_inflight_pc = 32'h0;
        m_run         = 1'b0;
    endtask

    task automatic check_outputs();
        logic taken;
        logic valid;
        taken      = ex_jump[1] | (ex_branch[1] & (ex_zero == ex_branch[0]));
        e_redirect = m_run & taken;
        e_rpc      = (ex_jump == 2'b11) ? (ex_alu_result & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        valid      = (q.size() > 0);
        e_pop      = valid & instr_ready;
        e_req      = m_run & !e_redirect &
                     ((q.size() + int'(m_inflight) - int'(e_pop)) < 2);
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("redirect", {31'b0, redirect}, {31'b0, e_redirect});
        if (e_redirect) chk("redirect_pc", redirect_pc, e_rpc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, valid});
        if (valid) begin
            chk("instr", instr, q[0].word);
            chk("instr_pc", instr_pc, q[0].pc);
            if (e_pop && !e_redirect)
                $display("accept pc=%h instr=%h t=%0t", instr_pc, instr, $time);
        end
        mem_req_q  = imem_req;
        mem_addr_q = imem_addr;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            if (e_redirect) begin
                q.delete();
                m_pc       = e_rpc;
                m_inflight = 1'b0;
            end else begin
                if (e_pop) void'(q.pop_front());
                if (m_inflight) q.push_back({m_inflight_pc ^ K, m_inflight_pc});
                if (e_req) begin
                    m_inflight_pc = m_pc;
                    m_pc          = m_pc + 32'd4;
                end
                m_inflight = e_req;
            end
            m_run = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
        imem_rdata = mem_req_q ? (mem_addr_q ^ K) : 32'hBAD0_BAD0;
    endtask

    task automatic clear_ex();
        ex_branch     = BR_NONE;
        ex_jump       = JMP_NONE;
        ex_zero       = 1'b0;
        ex_pc         = 32'h0;
        ex_imm        = 32'h0;
        ex_alu_result = 32'h0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_ready = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        clear_ex();
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);

        // Startup: BOOT cycle, then one instruction per cycle from address 0.
        rst = 1'b0;
        #1 chk("boot_req", {31'b0, imem_req}, 32'd0);
        cycle();
        cycle();
        chk("lat_not_yet", {31'b0, instr_valid}, 32'd0);
        cycle();
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_pc", instr_pc, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk("stream_pc", instr_pc, 32'(4 * k));
        end

        // Back-pressure: head 0x18 held for five cycles, issue stops.
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_req", {31'b0, imem_req}, 32'd0);
            chk("bp_pc", instr_pc, 32'h18);
            chk("bp_instr", instr, 32'h18 ^ K);
            cycle();
        end
        instr_ready = 1'b1;
        #1 chk("rel_pc0", instr_pc, 32'h18);
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        cycle();
        chk("rel_pc1", instr_pc, 32'h1C);
        cycle();
        chk("rel_pc2", instr_pc, 32'h20);
        cycle();

        // BEQ taken with a word in flight.
        ex_branch = BR_BEQ; ex_pc = 32'h10; ex_imm = 32'h20; ex_zero = 1'b1;
        #1 chk("beq_redirect", {31'b0, redirect}, 32'd1);
        chk("beq_target", redirect_pc, 32'h30);
        chk("beq_noreq", {31'b0, imem_req}, 32'd0);
        cycle();
        clear_ex();
        #1 chk("beq_t1_req", {31'b0, imem_req}, 32'd1);
        chk("beq_t1_addr", imem_addr, 32'h30);
        chk("beq_t1_valid", {31'b0, instr_valid}, 32'd0);
        cycle();
        cycle();
        chk("beq_t3_valid", {31'b0, instr_valid}, 32'd1);
        chk("beq_t3_pc", instr_pc, 32'h30);

        // BNE with zero set: not taken.  BNE with zero clear: wrapping add.
        ex_branch = BR_BNE; ex_zero = 1'b1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
        #1 chk("bne_z_redirect", {31'b0, redirect}, 32'd0);
        cycle();
        ex_zero = 1'b0;
        #1 chk("bne_nz_redirect", {31'b0, redirect}, 32'd1);
        chk("bne_nz_target", redirect_pc, 32'hF0);
        cycle();
        clear_ex();
        for (int k = 0; k < 3; k++) cycle();

        // JALR clears bit 0; JAL target wraps past 2^32.
        ex_jump = JMP_JALR; ex_alu_result = 32'h0000_0105;
        #1 chk("jalr_target", redirect_pc, 32'h104);
        cycle();
        clear_ex();
        for (int k = 0; k < 3; k++) cycle();
        ex_jump = JMP_JAL; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
        #1 chk("jal_target", redirect_pc, 32'h10);
        cycle();
        clear_ex();
        cycle();

        // Fill the buffer, then redirect while popping.
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("full_req", {31'b0, imem_req}, 32'd0);
        instr_ready = 1'b1;
        ex_jump = JMP_JAL; ex_pc = 32'h200; ex_imm = 32'h40;
        #1 chk("full_redirect", redirect_pc, 32'h240);
        chk("full_noreq", {31'b0, imem_req}, 32'd0);
        cycle();
        clear_ex();
        #1 chk("flush_empty", {31'b0, instr_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h240);
        cycle();
        cycle();
        chk("flush_t3_pc", instr_pc, 32'h240);
        for (int k = 0; k < 3; k++) cycle();

        // One-cycle reset mid-stream.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1 chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc", instr_pc, 32'h0);
        cycle();
        cycle();
        cycle();
        chk("restart_pc", instr_pc, 32'h0);
        chk("restart_valid", {31'b0, instr_valid}, 32'd1);

        // Irregular ready pattern, model checked each cycle.
        for (int k = 0; k < 24; k++) begin
            instr_ready = ((32'h00B3_6D5A >> k) & 32'h1) != 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
